multi_edge_detector: RTL
========================

Name: multi_edge_detector

Overview:
Parametrised multi-channel successor to the single-bit dual-edge detector. Each of WIDTH asynchronous level inputs is synchronised and passed through a stability (glitch/debounce) filter. A per-channel mode then selects rising, falling, both or no edges, and each selected edge produces a one-clock pulse. The block sits between raw board inputs (buttons, switches, external strobes) and control FSMs that need clean single-cycle event ticks.

Parameters:
WIDTH, 8, number of independent channels (≥1)
SYNC_STAGES, 2, synchroniser flops per channel (≥2)
STABLE_CYCLES, 4, consecutive cycles a new synchronised level must persist before it is accepted (≥1; 1 = no filtering)

Ports:
clk  in  1  system clock; all logic on posedge
rst_n  in  1  asynchronous active-low reset
level  in  WIDTH  raw asynchronous inputs
mode  in  2*WIDTH  per-channel mode, bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
state  out  WIDTH  filtered, debounced level per channel
edg  out  WIDTH  one-cycle pulse on a selected edge
rise  out  WIDTH  one-cycle pulse on every accepted rising edge, independent of mode
fall  out  WIDTH  one-cycle pulse on every accepted falling edge, independent of mode
clr  in  WIDTH  write-1-to-clear for pend (active only with the optional feature)
pend  out  WIDTH  sticky edge flags
irq  out  1  OR of pend

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: all synchroniser flops, state, counters, edg, rise, fall, pend and irq are 0.
- Reset mid-operation:
  - A partial filter count is discarded.
  - A level held high through reset release yields one rise after full latency.
- Synchroniser: a SYNC_STAGES-deep shift chain per channel. The output s[i] is the last stage.
- Filter, per channel, holding filtered level f (= state[i]) and counter c of width clog2(STABLE_CYCLES+1):
  - If s == f: c <= 0.
  - If s != f and c == STABLE_CYCLES-1: f <= s, c <= 0. This update is the accept event.
  - Otherwise (s != f): c <= c+1.
  - If s returns to f before acceptance, c clears. No edge is produced and no partial credit is kept.
- Outputs: rise, fall and edg are registered and assert in the same cycle that state changes.
  - rise = accept & new f == 1; fall = accept & new f == 0.
  - edg = (rise & mode bit0) | (fall & mode bit1).
  - Each pulse lasts exactly one cycle.
- Latency: if level changes before posedge k and holds, the pulse is high from posedge k+SYNC_STAGES+STABLE_CYCLES-1 for exactly one cycle. With the defaults this is posedge k+5.
- Level held for many cycles: exactly one rise pulse and, on release, one fall pulse.
- Mode:
  - Sampled combinationally at the accept cycle; a mode change takes effect on the next accept.
  - state, rise and fall keep tracking in mode 00.
- Channels are fully independent; simultaneous accepts on several channels each pulse in the same cycle.

Optional Feature:
Macro EDGE_DET_STICKY_EN.
- Defined:
  - pend[i] <= 1 on edg[i].
  - pend[i] <= 0 when clr[i] = 1.
  - If edg[i] and clr[i] occur in the same cycle, set wins.
  - irq = |pend, driven from registers, so irq goes high the cycle after edg.
- Undefined: pend and irq are tied 0 and clr is ignored. The port list is unchanged.

Decomposition:
- Package edge_det_pkg holds:
  - mode encodings MODE_OFF = 2'b00, MODE_RISE = 2'b01, MODE_FALL = 2'b10, MODE_BOTH = 2'b11;
  - a constant function for the counter width.
- Sub-module edge_det_chan contains one channel's synchroniser, filter, counter and rise/fall/edg registers. The top generates WIDTH instances and, when the macro is enabled, the sticky/irq logic.

Test Plan:
(All scenarios use WIDTH=4, SYNC_STAGES=2, STABLE_CYCLES=4, macro defined.)
1. Reset, level=0, mode[0]=01; raise level[0] before posedge 10 and hold 10 cycles -> state[0] and rise[0]/edg[0] high only in the cycle after posedge 15; the later fall gives fall[0]=1 and edg[0]=0.
2. mode[1]=11:
   - a level[1] pulse lasting 1, 2 and 3 cycles -> no rise/fall/edg, state[1] stays 0;
   - a pulse held 4 cycles -> one edg on the rise and one edg on the fall, each 1 cycle, 4 cycles apart.
3. mode=00 on ch2 with edges applied -> rise/fall/state track, edg[2] never asserts; switch to 10 mid-high -> the next fall produces edg[2].
4. All four channels toggle on the same cycle with modes 01/10/11/00 -> edg = 4'b0101 on the rise accept cycle, 4'b0110 on the fall accept cycle.
5. Sticky behaviour:
   - edg[0] -> pend[0]=1 and irq=1 next cycle;
   - clr[0] pulse -> pend[0]=0 and irq=0;
   - clr[0] asserted in the same cycle as a new edg[0] -> pend[0] remains 1.
6. Reset mid-filter:
   - Hold level[3]=1 until c=2, assert rst_n=0 for 2 cycles, release with level[3]=1 -> all outputs 0 during reset, then exactly one rise[3] 6 cycles after release.
   - A rebuild without EDGE_DET_STICKY_EN -> pend=0 and irq=0 throughout.

Source files
------------

// File: rtl/edge_det_pkg.sv
// rtl/edge_det_pkg.sv - shared mode encodings and counter sizing for the multi-channel edge detector
package edge_det_pkg;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    // Counter must hold 0..STABLE_CYCLES-1 and never collapse below one bit.
    function automatic int cnt_width(input int stable_cycles);
        return (stable_cycles < 1) ? 1 : $clog2(stable_cycles + 1);
    endfunction

endpackage

// File: rtl/edge_det_chan.sv
// rtl/edge_det_chan.sv - one channel: synchroniser, stability filter and registered rise/fall/edg pulses
module edge_det_chan
    import edge_det_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       level,
    input  logic [1:0] mode,
    output logic       state,
    output logic       edg,
    output logic       rise,
    output logic       fall
);

    localparam int             CW   = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt;
    logic                   s;
    logic                   accept;
    logic                   want_rise;
    logic                   want_fall;

    assign s         = sync_q[SYNC_STAGES-1];
    assign accept    = (s != state) && (cnt == LAST);
    assign want_rise = (mode == MODE_RISE) || (mode == MODE_BOTH);
    assign want_fall = (mode == MODE_FALL) || (mode == MODE_BOTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt    <= '0;
            state  <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
            edg    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], level};
            rise   <= accept & s;
            fall   <= accept & ~s;
            edg    <= accept & ((s & want_rise) | (~s & want_fall));
            // A return to the filtered level discards any partial run.
            if (s == state) begin
                cnt <= '0;
            end else if (accept) begin
                state <= s;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/multi_edge_detector.sv
// rtl/multi_edge_detector.sv - WIDTH-channel debounced edge detector; EDGE_DET_STICKY_EN adds pend/irq
module multi_edge_detector
    import edge_det_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   level,
    input  logic [2*WIDTH-1:0] mode,
    output logic [WIDTH-1:0]   state,
    output logic [WIDTH-1:0]   edg,
    output logic [WIDTH-1:0]   rise,
    output logic [WIDTH-1:0]   fall,
    input  logic [WIDTH-1:0]   clr,
    output logic [WIDTH-1:0]   pend,
    output logic               irq
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        edge_det_chan #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_chan (
            .clk  (clk),
            .rst_n(rst_n),
            .level(level[i]),
            .mode (mode[2*i +: 2]),
            .state(state[i]),
            .edg  (edg[i]),
            .rise (rise[i]),
            .fall (fall[i])
        );
    end

`ifdef EDGE_DET_STICKY_EN
    // Set has priority over clear so an edge coinciding with clr is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~clr) | edg;
        end
    end

    assign irq = |pend;
`else
    logic unused_clr;

    assign unused_clr = ^clr;
    assign pend       = '0;
    assign irq        = 1'b0;
`endif

endmodule
